// File: rtl/dmem_arb_pkg.sv
// Purpose: shared widths, camera entry layout and arbiter state encoding for the DMEM write path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

  localparam int DMEM_DATA_W = 256;
  localparam int DMEM_ADDR_W = 7;

  // Camera write-buffer entry at the default DMEM widths.
  typedef struct packed {
    logic                   last;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] data;
  } ccd_entry_t;

  // Each state records which requester won the previous cycle.
  typedef enum logic [1:0] {
    IDLE,
    CCD,
    SP
  } arb_state_t;

endpackage

// File: rtl/ccd_wr_fifo.sv
// Purpose: small synchronous FIFO buffering camera writes ahead of the DMEM arbiter.
// Latency: a push is visible at head_dat on the next cycle; pop consumes the current head.
// Backpressure: none upstream; a push while full is accepted only if a pop happens in the same cycle.
//
// Ports: CLOCK_50/rst clock and async reset; push/push_dat write side;
//        pop/head_dat read side; full/empty occupancy status.
module ccd_wr_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output T     head_dat,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only read while the FIFO is non-empty.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dmem_wr_arbiter.sv
// Purpose: merges buffered camera writes and SPART loader writes onto one registered DMEM write port.
// Latency: SPART accept -> dmem write 1 cycle; camera strobe -> dmem write 2 cycles when uncontended.
// Backpressure: SPART via sp_ready; camera has none, so writes arriving at a full buffer are dropped and flagged.
//
// Ports: CLOCK_50/rst clock and async reset; ccd_* camera write strobe, address, data, frame-last;
//        sp_valid/sp_addr/sp_data/sp_ready SPART request handshake; clr clears ccd_overflow;
//        dmem_wren/dmem_wraddr/dmem_wrdata registered DMEM write; frame_done last-write pulse.
module dmem_wr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W         = DMEM_DATA_W,
  parameter int ADDR_W         = DMEM_ADDR_W,
  parameter int CCD_FIFO_DEPTH = 2,
  parameter int CCD_BURST_MAX  = 4
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              ccd_wren,
  input  logic [ADDR_W-1:0] ccd_wraddr,
  input  logic [DATA_W-1:0] ccd_wrdata,
  input  logic              ccd_last,
  input  logic              sp_valid,
  input  logic [ADDR_W-1:0] sp_addr,
  input  logic [DATA_W-1:0] sp_data,
  output logic              sp_ready,
  input  logic              clr,
  output logic              dmem_wren,
  output logic [ADDR_W-1:0] dmem_wraddr,
  output logic [DATA_W-1:0] dmem_wrdata,
  output logic              frame_done,
  output logic              ccd_overflow
);

  // Same layout as ccd_entry_t, but follows this instance's width parameters.
  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int BW = $clog2(CCD_BURST_MAX + 1);

  arb_state_t    state_q;
  arb_state_t    state_nxt;
  logic [BW-1:0] burst_cnt;
  logic          grant_ccd;
  logic          grant_sp;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ccd_drop;
  entry_t        push_dat;
  entry_t        head_dat;

  assign push_dat = '{last: ccd_last, addr: ccd_wraddr, data: ccd_wrdata};

  ccd_wr_fifo #(
    .DEPTH (CCD_FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .push     (ccd_wren),
    .push_dat (push_dat),
    .pop      (grant_ccd),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A full buffer only makes room when the head is granted this same cycle.
  assign ccd_drop = ccd_wren && fifo_full && !grant_ccd;

  // Camera wins by default; after CCD_BURST_MAX back-to-back camera grants
  // with SPART waiting, SPART gets exactly one turn. Gated by rst so
  // sp_ready reads 0 while the block is held in reset.
  always_comb begin
    grant_ccd = 1'b0;
    grant_sp  = 1'b0;
    state_nxt = IDLE;
    if (!rst) begin
      if (!fifo_empty && !(sp_valid && (burst_cnt == BW'(CCD_BURST_MAX)))) begin
        grant_ccd = 1'b1;
      end else if (sp_valid) begin
        grant_sp = 1'b1;
      end
    end
    if (grant_ccd) begin
      state_nxt = CCD;
    end else if (grant_sp) begin
      state_nxt = SP;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  assign sp_ready  = grant_sp;
  // The state register doubles as the write strobe: any grant last cycle is a write now.
  assign dmem_wren = (state_q != IDLE);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      dmem_wraddr  <= '0;
      dmem_wrdata  <= '0;
      frame_done   <= 1'b0;
      burst_cnt    <= '0;
      ccd_overflow <= 1'b0;
    end else begin
      frame_done <= grant_ccd && head_dat.last;

      if (grant_ccd) begin
        dmem_wraddr <= head_dat.addr;
        dmem_wrdata <= head_dat.data;
      end else if (grant_sp) begin
        dmem_wraddr <= sp_addr;
        dmem_wrdata <= sp_data;
      end

      // Counts camera grants only while SPART is actually waiting.
      if (!sp_valid || grant_sp) begin
        burst_cnt <= '0;
      end else if (grant_ccd && (burst_cnt != BW'(CCD_BURST_MAX))) begin
        burst_cnt <= burst_cnt + BW'(1);
      end

      // A new drop outranks clr in the same cycle.
      if (ccd_drop) begin
        ccd_overflow <= 1'b1;
      end else if (clr) begin
        ccd_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_wr_arbiter.sv
// Purpose: self-checking bench for dmem_wr_arbiter with a cycle-level reference model and scoreboard.
// Latency: expected outputs are queued when stimulus is applied and compared after the next edge.
// Backpressure: SPART stimulus advances its address only when sp_ready is seen.
module tb_dmem_wr_arbiter;

  localparam int DW    = 256;
  localparam int AW    = 7;
  localparam int DEPTH = 2;
  localparam int BURST = 4;

  logic          CLOCK_50 = 1'b0;
  logic          rst = 1'b1;
  logic          ccd_wren = 1'b0;
  logic [AW-1:0] ccd_wraddr = '0;
  logic [DW-1:0] ccd_wrdata = '0;
  logic          ccd_last = 1'b0;
  logic          sp_valid = 1'b0;
  logic [AW-1:0] sp_addr = '0;
  logic [DW-1:0] sp_data = '0;
  logic          sp_ready;
  logic          clr = 1'b0;
  logic          dmem_wren;
  logic [AW-1:0] dmem_wraddr;
  logic [DW-1:0] dmem_wrdata;
  logic          frame_done;
  logic          ccd_overflow;

  dmem_wr_arbiter #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .CCD_FIFO_DEPTH (DEPTH),
    .CCD_BURST_MAX  (BURST)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .rst          (rst),
    .ccd_wren     (ccd_wren),
    .ccd_wraddr   (ccd_wraddr),
    .ccd_wrdata   (ccd_wrdata),
    .ccd_last     (ccd_last),
    .sp_valid     (sp_valid),
    .sp_addr      (sp_addr),
    .sp_data      (sp_data),
    .sp_ready     (sp_ready),
    .clr          (clr),
    .dmem_wren    (dmem_wren),
    .dmem_wraddr  (dmem_wraddr),
    .dmem_wrdata  (dmem_wrdata),
    .frame_done   (frame_done),
    .ccd_overflow (ccd_overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct packed {
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          fd;
    logic          ovf;
  } out_t;

  // Reference model state
  ent_t          mq[$];
  int            mburst = 0;
  logic          movf = 1'b0;
  logic [AW-1:0] mh_addr = '0;
  logic [DW-1:0] mh_data = '0;
  out_t          exp_q[$];

  // Counters and logs
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  bit            last_sp_rdy = 1'b0;
  int            sp_rdy_cnt = 0;
  int            fd_cnt = 0;
  logic [AW-1:0] fd_addr = '0;
  logic          fd_wren = 1'b0;
  int            wr_addr_q[$];
  int            wr_cyc_q[$];

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: model the grant for the currently driven inputs,
  // queue the expected registered outputs, then compare after the edge.
  task automatic tick();
    bit   g_ccd;
    bit   g_sp;
    out_t e;
    ent_t hd;
    #1;
    g_ccd = 1'b0;
    g_sp  = 1'b0;
    if (!rst) begin
      if (mq.size() != 0 && !(sp_valid && mburst == BURST)) g_ccd = 1'b1;
      else if (sp_valid) g_sp = 1'b1;
    end
    check_val("sp_ready", sp_ready, g_sp);
    last_sp_rdy = sp_ready;
    if (sp_ready) sp_rdy_cnt++;

    e = '0;
    if (rst) begin
      mq.delete();
      mburst  = 0;
      movf    = 1'b0;
      mh_addr = '0;
      mh_data = '0;
    end else begin
      if (g_ccd) begin
        hd      = mq.pop_front();
        mh_addr = hd.addr;
        mh_data = hd.data;
        e.wren  = 1'b1;
        e.fd    = hd.last;
      end else if (g_sp) begin
        mh_addr = sp_addr;
        mh_data = sp_data;
        e.wren  = 1'b1;
      end
      if (ccd_wren) begin
        if (mq.size() < DEPTH) mq.push_back('{last: ccd_last, addr: ccd_wraddr, data: ccd_wrdata});
        else movf = 1'b1;
      end
      if (clr && !(ccd_wren && mq.size() >= DEPTH && !g_ccd)) begin
        if (!(ccd_wren && !g_ccd && mq.size() == DEPTH)) movf = movf && !clr;
      end
      if (!sp_valid || g_sp) mburst = 0;
      else if (g_ccd && mburst < BURST) mburst++;
    end
    e.addr = mh_addr;
    e.data = mh_data;
    e.ovf  = movf;
    exp_q.push_back(e);

    @(posedge CLOCK_50);
    cyc++;
    @(negedge CLOCK_50);
    e = exp_q.pop_front();
    check_val("dmem_wren", dmem_wren, e.wren);
    check_val("dmem_wraddr", dmem_wraddr, e.addr);
    check_val("dmem_wrdata", dmem_wrdata, e.data);
    check_val("frame_done", frame_done, e.fd);
    check_val("ccd_overflow", ccd_overflow, e.ovf);
    if (dmem_wren) begin
      wr_addr_q.push_back(int'(dmem_wraddr));
      wr_cyc_q.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_addr = dmem_wraddr;
      fd_wren = dmem_wren;
    end
  endtask

  task automatic drive_idle();
    ccd_wren = 1'b0;
    ccd_last = 1'b0;
    sp_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_cyc_q.delete();
    sp_rdy_cnt = 0;
    fd_cnt     = 0;
  endtask

  // Camera writes on cycles [0, n_ccd) at addr 0x10+t; SPART requests on
  // cycles [sp_from, sp_to) at addr 0x40+k, advancing k on each acceptance.
  task automatic run_mix(input int n_ccd, input int sp_from, input int sp_to,
                         input int n_cyc, input int last_from);
    int k = 0;
    for (int t = 0; t < n_cyc; t++) begin
      ccd_wren   = (t < n_ccd);
      ccd_wraddr = AW'(8'h10 + t);
      ccd_wrdata = {8{32'(t)}};
      ccd_last   = (t < n_ccd) && (t >= last_from);
      sp_valid   = (t >= sp_from) && (t < sp_to);
      sp_addr    = AW'(8'h40 + k);
      sp_data    = {8{32'hC0DE0000 + 32'(k)}};
      tick();
      if (last_sp_rdy) k++;
    end
    drive_idle();
  endtask

  initial begin
    int base;
    int n_hit;
    logic [8:0] pat;

    // Reset state
    for (int i = 0; i < 3; i++) tick();
    check_val("reset_wren", dmem_wren, 1'b0);
    check_val("reset_wraddr", dmem_wraddr, '0);
    check_val("reset_wrdata", dmem_wrdata, '0);
    check_val("reset_overflow", ccd_overflow, 1'b0);
    rst = 1'b0;

    // Single camera write at cycle 10 lands at cycle 12
    drive_idle();
    while (cyc < 10) tick();
    clear_logs();
    ccd_wren   = 1'b1;
    ccd_wraddr = 7'h05;
    ccd_wrdata = {32{8'hA5}};
    tick();
    idle_ticks(4);
    check_val("single_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check_val("single_cycle", wr_cyc_q[0], 12);
      check_val("single_addr", wr_addr_q[0], 32'h05);
    end
    check_val("single_sp_ready", sp_rdy_cnt, 0);

    // SPART alone: three accepts, each written one cycle later
    clear_logs();
    base = cyc;
    for (int i = 0; i < 3; i++) begin
      sp_valid = 1'b1;
      sp_addr  = AW'(i);
      sp_data  = {8{32'h5A5A0000 + 32'(i)}};
      tick();
    end
    idle_ticks(3);
    check_val("spart_ready_cnt", sp_rdy_cnt, 3);
    check_val("spart_wr_count", wr_addr_q.size(), 3);
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      check_val("spart_addr", wr_addr_q[i], i);
      check_val("spart_cycle", wr_cyc_q[i], base + i + 1);
    end

    // Contention: 4 camera, 1 SPART, 4 camera with no drops
    clear_logs();
    run_mix(8, 1, 11, 11, 99);
    idle_ticks(3);
    pat = '0;
    for (int i = 0; i < 9 && i < wr_addr_q.size(); i++) pat = {pat[7:0], wr_addr_q[i] >= 8'h40};
    check_val("contention_pattern", pat, 9'b000010000);
    n_hit = 0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] < 8'h40) n_hit++;
    check_val("contention_ccd_writes", n_hit, 8);
    check_val("contention_no_overflow", ccd_overflow, 1'b0);

    // Overflow: sustained camera writes into a full buffer on SPART's turn
    clear_logs();
    run_mix(11, 1, 14, 14, 99);
    idle_ticks(3);
    check_val("overflow_flag", ccd_overflow, 1'b1);
    n_hit = 0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] == 8'h1A) n_hit++;
    check_val("overflow_dropped_absent", n_hit, 0);
    n_hit = 0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] < 8'h40) n_hit++;
    check_val("overflow_ccd_writes", n_hit, 10);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("overflow_cleared", ccd_overflow, 1'b0);
    idle_ticks(2);

    // Frame end: 49 writes, last at 0x30
    clear_logs();
    for (int t = 0; t < 49; t++) begin
      ccd_wren   = 1'b1;
      ccd_wraddr = AW'(t);
      ccd_wrdata = {8{32'hF0000000 + 32'(t)}};
      ccd_last   = (t == 48);
      tick();
    end
    idle_ticks(4);
    check_val("frame_writes", wr_addr_q.size(), 49);
    check_val("frame_done_count", fd_cnt, 1);
    check_val("frame_done_addr", fd_addr, 7'h30);
    check_val("frame_done_wren", fd_wren, 1'b1);

    // Reset mid-stream with two buffered last-marked entries
    run_mix(6, 1, 6, 6, 4);
    clear_logs();
    rst = 1'b1;
    tick();
    check_val("rst_mid_wren", dmem_wren, 1'b0);
    check_val("rst_mid_wraddr", dmem_wraddr, '0);
    check_val("rst_mid_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    idle_ticks(6);
    check_val("rst_mid_no_writes", wr_addr_q.size(), 0);
    check_val("rst_mid_no_frame_done", fd_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_wr_arbiter.md
DMEM_WR_ARBITER -- requirements
Module: dmem_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 256, is the DMEM write data width.
REQ-002 Parameter ADDR_W, default 7, is the DMEM write address width.
REQ-003 Parameter CCD_FIFO_DEPTH, default 2, is the number of camera write-buffer entries.
REQ-004 Parameter CCD_BURST_MAX, default 4, is the maximum number of consecutive camera grants while SPART is waiting.
REQ-005 Port: CLOCK_50  input  1  the single clock, rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous and active-high.
REQ-007 Port: ccd_wren  input  1  camera write strobe; the camera side has no backpressure.
REQ-008 Port: ccd_wraddr  input  ADDR_W  camera write address.
REQ-009 Port: ccd_wrdata  input  DATA_W  camera write data.
REQ-010 Port: ccd_last  input  1  qualifies ccd_wren as the final write of a frame.
REQ-011 Port: sp_valid  input  1  SPART loader write request.
REQ-012 Port: sp_addr  input  ADDR_W  SPART write address.
REQ-013 Port: sp_data  input  DATA_W  SPART write data.
REQ-014 Port: sp_ready  output  1  SPART request accepted this cycle.
REQ-015 Port: clr  input  1  synchronous clear of ccd_overflow.
REQ-016 Ports: dmem_wren  output  1; dmem_wraddr  output  ADDR_W; dmem_wrdata  output  DATA_W; together these form the registered DMEM write port.
REQ-017 Port: frame_done  output  1  one-cycle pulse for the committed last camera write.
REQ-018 Port: ccd_overflow  output  1  sticky flag indicating a camera write was dropped.

Function
REQ-019 A camera write (ccd_wren=1) SHALL push {ccd_last, ccd_wraddr, ccd_wrdata} into the camera FIFO.
REQ-020 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-021 Any other push while full SHALL drop the entry and set ccd_overflow, which stays set until clr=1 or reset; clr and a new drop in the same cycle leave the flag set.
REQ-022 The FSM SHALL have three states, each recording the last grant:
- IDLE: no grant;
- CCD: the FIFO head was popped;
- SP: the SPART request was accepted.
The state transition is evaluated every cycle.
REQ-023 Priority: the FIFO SHALL be granted when non-empty, except when burst_cnt==CCD_BURST_MAX and sp_valid=1, in which case SP is granted instead.
REQ-024 SP SHALL be granted when the FIFO is empty and sp_valid=1; IDLE results when neither requester is pending.
REQ-025 burst_cnt SHALL increment on each CCD grant while sp_valid=1, saturating at CCD_BURST_MAX.
REQ-026 burst_cnt SHALL clear on any SP grant, or on any cycle with sp_valid=0.
REQ-027 sp_ready SHALL be combinational, high only in a cycle in which SP is granted; sp_ready=1 requires sp_valid=1.
REQ-028 A grant in cycle N SHALL drive dmem_wren=1 in cycle N+1, with the granted address and data, from registers.
REQ-029 Camera latency: ccd_wren in cycle N into an empty FIFO with SPART idle SHALL produce dmem_wren in cycle N+2.
REQ-030 SPART latency: acceptance in cycle N SHALL produce dmem_wren in cycle N+1.
REQ-031 dmem_wren SHALL be 0 in any cycle following a non-grant cycle; dmem_wraddr and dmem_wrdata hold their previous values.
REQ-032 frame_done SHALL pulse high in the same cycle as the dmem_wren of an entry whose last bit is 1.
REQ-033 A dropped last entry SHALL produce no frame_done pulse.
REQ-034 The FIFO SHALL be first-in first-out; its pointers wrap modulo CCD_FIFO_DEPTH.

Reset
REQ-035 During rst=1 the block SHALL hold: dmem_wren=0, dmem_wraddr=0, dmem_wrdata=0, sp_ready=0, frame_done=0, ccd_overflow=0, FIFO empty, burst_cnt=0, state IDLE.
REQ-036 A reset asserted mid-stream SHALL discard all buffered camera entries; no write or frame_done SHALL issue for them after release.
REQ-037 Normal operation SHALL begin on the first rising edge after rst deasserts.

Structure
REQ-038 Package dmem_arb_pkg SHALL hold the DATA_W and ADDR_W defaults, the ccd_entry_t struct {last, addr, data}, and the arb_state_t enum {IDLE, CCD, SP}.
REQ-039 The camera buffer SHALL be the sub-module ccd_wr_fifo: a synchronous FIFO with push, pop, full and empty, parameterised on depth and entry type.
REQ-040 Arbitration, the burst counter and the output registers SHALL reside in dmem_wr_arbiter.

Verification
REQ-041 Single camera write: ccd_wren at cycle 10, addr 0x05, data 0xA5 repeated -> dmem_wren=1 at cycle 12 with addr 0x05 and the same data; sp_ready stays 0.
REQ-042 Contention: FIFO holds 2 entries and sp_valid=1 continuously, with camera writes sustained -> 4 CCD writes, 1 SP write, 4 CCD writes; no camera entry is dropped at a one-write-per-cycle input rate once steady.
REQ-043 Overflow: 3 back-to-back ccd_wren while sp_valid=1 and burst_cnt=4 -> third entry dropped, ccd_overflow=1; clr=1 -> ccd_overflow=0 next cycle.
REQ-044 Frame end: 49 camera writes, the last with ccd_last=1 at addr 0x30 -> exactly one frame_done pulse, coincident with dmem_wren at addr 0x30.
REQ-045 Reset mid-stream: rst=1 for 1 cycle while the FIFO holds 2 entries -> outputs read 0, no later writes for those entries, and no frame_done.
REQ-046 SPART alone: sp_valid=1 for 3 cycles, addrs 0x00/0x01/0x02 -> sp_ready=1 in each of those cycles, and dmem writes at the same three addrs one cycle later each.
